// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, odd parity, one stop bit, idle-high line.
// Samples the synchronized line at mid-bit and reports each completed frame with a one-cycle strobe.
module uart_rx #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Sin,
    output logic       Receive,
    output logic [7:0] Dout,
    output logic       parityErr,
    output logic       frameErr,
    output logic       Busy
);

    localparam int BIT_CYCLES  = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int TW          = $clog2(BIT_CYCLES);

    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CYCLES - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] BRK   = 3'd5;

    logic          sync1_q, sin_s_q;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_num_q, bit_num_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [7:0]    dout_q, dout_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          recv_q, recv_d;
    logic          busy_q, busy_d;
    logic          bit_end_s;

    assign bit_end_s = (timer_q == BIT_LAST);

    // Frame sequencing, deserialization and completion status.
    always_comb begin
        state_d   = state_q;
        bit_num_d = bit_num_q;
        shift_d   = shift_q;
        par_d     = par_q;
        dout_d    = dout_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        recv_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sin_s_q) state_d = START;
                else          state_d = IDLE;
            end
            START: begin
                // A line that is high again at mid-start-bit was a glitch.
                if (timer_q == HALF_LAST) begin
                    if (!sin_s_q) begin
                        state_d   = DATA;
                        bit_num_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_d   = {sin_s_q, shift_q[7:1]};
                    bit_num_d = bit_num_q + 3'd1;
                    if (bit_num_q == 3'd7) state_d = PAR;
                    else                   state_d = DATA;
                end else begin
                    state_d = DATA;
                end
            end
            PAR: begin
                if (bit_end_s) begin
                    par_d   = sin_s_q;
                    state_d = STOP;
                end else begin
                    state_d = PAR;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    recv_d  = 1'b1;
                    dout_d  = shift_q;
                    perr_d  = ~(^{shift_q, par_q});
                    ferr_d  = ~sin_s_q;
                    state_d = sin_s_q ? IDLE : BRK;
                end else begin
                    state_d = STOP;
                end
            end
            BRK: begin
                if (sin_s_q) state_d = IDLE;
                else         state_d = BRK;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timer restarts on every state change and at its terminal count.
    always_comb begin
        if ((state_d != state_q) || bit_end_s) timer_d = {TW{1'b0}};
        else                                   timer_d = timer_q + TW'(1);
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers; the synchronizer idles high.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sync1_q   <= 1'b1;
            sin_s_q   <= 1'b1;
            state_q   <= IDLE;
            timer_q   <= {TW{1'b0}};
            bit_num_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            dout_q    <= 8'd0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            recv_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync1_q   <= Sin;
            sin_s_q   <= sync1_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_num_q <= bit_num_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            dout_q    <= dout_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            recv_q    <= recv_d;
            busy_q    <= busy_d;
        end
    end

    assign Receive   = recv_q;
    assign Dout      = dout_q;
    assign parityErr = perr_q;
    assign frameErr  = ferr_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frame results, a monitor pops
// them on every Receive strobe. Expected status comes from counting ones in the sent bits.
module tb_uart_rx;

    localparam int BITC = 10;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Sin;
    logic       Receive;
    logic [7:0] Dout;
    logic       parityErr;
    logic       frameErr;
    logic       Busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rx_count = 0;
    int   rx_last_t = 0;
    int   rx_prev_t = 0;
    int   t_fall = 0;
    logic prev_recv = 1'b0;

    uart_rx #(.CLK_FREQUENCY(1000), .BAUD_RATE(100)) dut (
        .CLK(CLK), .Reset(Reset), .Sin(Sin), .Receive(Receive),
        .Dout(Dout), .parityErr(parityErr), .frameErr(frameErr), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (Receive) begin
            exp_t e;
            chk("rx_not_back_to_back", {31'd0, prev_recv}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_receive: got Dout=%0h expected no strobe", Dout);
            end else begin
                e = sb.pop_front();
                chk("dout", {24'd0, Dout}, {24'd0, e.d});
                chk("parity_err", {31'd0, parityErr}, {31'd0, e.pe});
                chk("frame_err", {31'd0, frameErr}, {31'd0, e.fe});
            end
            rx_prev_t = rx_last_t;
            rx_last_t = cyc;
            rx_count++;
        end
        prev_recv = Receive;
    end

    // Drives one frame; rst_bit selects a bit slot (0=start, 1..8 data) for a mid-bit reset pulse.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input bit push, input int rst_bit);
        logic [10:0] bits;
        exp_t e;
        bits = {s, p, d, 1'b0};
        if (push) begin
            e.d  = d;
            e.pe = (($countones({d, p}) % 2) == 0);
            e.fe = (s == 1'b0);
            sb.push_back(e);
        end
        t_fall = cyc;
        for (int i = 0; i < 11; i++) begin
            Sin = bits[i];
            for (int j = 0; j < BITC; j++) begin
                if (i == rst_bit && j == 5) begin
                    Reset = 1'b1;
                    @(negedge CLK);
                    Reset = 1'b0;
                    chk("rst_receive", {31'd0, Receive}, 32'd0);
                    chk("rst_dout", {24'd0, Dout}, 32'd0);
                    chk("rst_perr", {31'd0, parityErr}, 32'd0);
                    chk("rst_ferr", {31'd0, frameErr}, 32'd0);
                    chk("rst_busy", {31'd0, Busy}, 32'd0);
                end else begin
                    @(negedge CLK);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        Sin = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int busy_cnt;
        int gap;
        logic [7:0] rd;
        logic       rp;
        Sin   = 1'b1;
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_receive", {31'd0, Receive}, 32'd0);
        chk("reset_dout", {24'd0, Dout}, 32'd0);
        chk("reset_perr", {31'd0, parityErr}, 32'd0);
        chk("reset_ferr", {31'd0, frameErr}, 32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        Reset = 1'b0;
        idle(20);

        // 1: clean frame, latency from falling edge of start bit
        base = rx_count;
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, -1);
        chk("t1_one_receive", rx_count, base + 1);
        chk("t1_latency_ok", {31'd0, ((rx_last_t - t_fall) >= 106) && ((rx_last_t - t_fall) <= 108)}, 32'd1);
        idle(20);
        chk("t1_busy_idle", {31'd0, Busy}, 32'd0);

        // 2: wrong parity
        send_frame(8'hA3, 1'b0, 1'b1, 1'b1, -1);
        idle(20);

        // 3: short glitch must not start a frame
        base = rx_count;
        Sin = 1'b0;
        repeat (3) @(negedge CLK);
        Sin = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (Busy) busy_cnt++;
        end
        chk("t3_busy_short", {31'd0, busy_cnt <= 8}, 32'd1);
        chk("t3_busy_low", {31'd0, Busy}, 32'd0);
        chk("t3_no_receive", rx_count, base);
        chk("t3_dout_held", {24'd0, Dout}, 32'hA3);
        chk("t3_perr_held", {31'd0, parityErr}, 32'd1);

        // 4: framing error followed by a long break, then a clean frame
        base = rx_count;
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, -1);
        Sin = 1'b0;
        repeat (40) @(negedge CLK);
        chk("t4_single_receive", rx_count, base + 1);
        chk("t4_busy_in_break", {31'd0, Busy}, 32'd1);
        idle(20);
        chk("t4_busy_after_break", {31'd0, Busy}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
        idle(20);

        // 5: reset during data bit 4 discards the frame
        base = rx_count;
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 5);
        idle(20);
        chk("t5_no_receive", rx_count, base);
        send_frame(8'hC8, 1'b0, 1'b1, 1'b1, -1);
        idle(20);

        // 6: back-to-back frames
        base = rx_count;
        send_frame(8'h01, 1'b0, 1'b1, 1'b1, -1);
        send_frame(8'hFE, 1'b0, 1'b1, 1'b1, -1);
        idle(20);
        chk("t6_two_receives", rx_count, base + 2);
        gap = rx_last_t - rx_prev_t;
        chk("t6_gap_ok", {31'd0, (gap >= 109) && (gap <= 111)}, 32'd1);

        // Random frames: occasional bad parity, random gaps including none
        for (int k = 0; k < 20; k++) begin
            rd = 8'($urandom_range(0, 255));
            rp = ($countones(rd) % 2 == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 3) == 0) rp = ~rp;
            send_frame(rd, rp, 1'b1, 1'b1, -1);
            idle($urandom_range(0, 12));
        end

        for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge CLK);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
